// File: rtl/logic_analyzer_trigger.sv
// Logic analyzer trigger: registered probes -> per-probe compare -> AND/OR combine -> arm/fire FSM.
// Define LA_TRIGGER_COUNT_EN to build the consecutive-match run counter and match_count qualification.
module logic_analyzer_trigger #(
    parameter int unsigned NUM_PROBES  = 2,
    parameter int unsigned PROBE_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PROBES*PROBE_WIDTH-1:0] probes,
    input  logic [NUM_PROBES*4-1:0]           ops,
    input  logic [NUM_PROBES*PROBE_WIDTH-1:0] args,
    input  logic                              mode_or,
    input  logic [15:0]                       match_count,
    input  logic                              arm,
    output logic                              trig,
    output logic [1:0]                        trig_state,
    output logic [15:0]                       run_length
);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_FIRED    = 2'd2
    } state_e;

    logic [NUM_PROBES*PROBE_WIDTH-1:0] p_q, q_q;
    logic                              pv_q, hv_q;
    logic [NUM_PROBES-1:0]             hit_v, en_v;
    logic                              match_d, match_q;
    logic                              arm_q, trig_q, fire;
    state_e                            state_q;

    // hv_q trails pv_q so edge operators stay false until q_q holds a real sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q  <= '0;
            q_q  <= '0;
            pv_q <= 1'b0;
            hv_q <= 1'b0;
        end else begin
            p_q  <= probes;
            q_q  <= p_q;
            pv_q <= 1'b1;
            hv_q <= pv_q;
        end
    end

    for (genvar g = 0; g < NUM_PROBES; g++) begin : g_probe
        logic [PROBE_WIDTH-1:0] cur, prev, cmp;
        logic [3:0]             op;
        logic                   hit, en;

        assign cur  = p_q[g*PROBE_WIDTH +: PROBE_WIDTH];
        assign prev = q_q[g*PROBE_WIDTH +: PROBE_WIDTH];
        assign cmp  = args[g*PROBE_WIDTH +: PROBE_WIDTH];
        assign op   = ops[g*4 +: 4];

        always_comb begin
            hit = 1'b0;
            en  = 1'b1;
            case (op)
                4'd1:    hit = hv_q && (cur > prev);
                4'd2:    hit = hv_q && (cur < prev);
                4'd3:    hit = hv_q && (cur != prev);
                4'd4:    hit = cur > cmp;
                4'd5:    hit = cur < cmp;
                4'd6:    hit = cur >= cmp;
                4'd7:    hit = cur <= cmp;
                4'd8:    hit = cur == cmp;
                4'd9:    hit = cur != cmp;
                default: en  = 1'b0;
            endcase
        end

        assign hit_v[g] = hit;
        assign en_v[g]  = en;
    end

    always_comb begin
        if (mode_or) match_d = |(hit_v & en_v);
        else         match_d = (|en_v) & (&(hit_v | ~en_v));
    end

    always_ff @(posedge clk) begin
        if (rst) match_q <= 1'b0;
        else     match_q <= match_d;
    end

`ifdef LA_TRIGGER_COUNT_EN
    logic [15:0] run_q, run_d, thresh;

    always_comb begin
        thresh = (match_count == 16'd0) ? 16'd1 : match_count;
        run_d  = '0;
        if (match_q) run_d = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;
        fire   = match_q && (run_d >= thresh);
    end

    assign run_length = run_q;
`else
    logic unused_match_count;

    assign unused_match_count = ^match_count;
    assign fire               = match_q;
    assign run_length         = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_DISARMED;
            arm_q   <= 1'b0;
            trig_q  <= 1'b0;
`ifdef LA_TRIGGER_COUNT_EN
            run_q   <= '0;
`endif
        end else begin
            arm_q <= arm;
            if (!arm) begin
                state_q <= ST_DISARMED;
                trig_q  <= 1'b0;
`ifdef LA_TRIGGER_COUNT_EN
                run_q   <= '0;
`endif
            end else begin
                case (state_q)
                    ST_DISARMED: begin
                        if (!arm_q) begin
                            state_q <= ST_ARMED;
`ifdef LA_TRIGGER_COUNT_EN
                            run_q   <= '0;
`endif
                        end
                    end
                    ST_ARMED: begin
`ifdef LA_TRIGGER_COUNT_EN
                        run_q <= run_d;
`endif
                        if (fire) begin
                            state_q <= ST_FIRED;
                            trig_q  <= 1'b1;
                        end
                    end
                    ST_FIRED: ;
                    default: begin
                        state_q <= ST_DISARMED;
                        trig_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign trig       = trig_q;
    assign trig_state = state_q;

endmodule

// File: tb/tb_logic_analyzer_trigger.sv
// Self-checking bench for logic_analyzer_trigger: directed scenarios plus randomized traffic
// checked every cycle against a history-based reference model.
module tb_logic_analyzer_trigger;

    localparam int NP   = 2;
    localparam int PW   = 8;
    localparam int MAXN = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] probes, args, match_count, run_length;
    logic [7:0]  ops;
    logic        mode_or, arm, trig;
    logic [1:0]  trig_state;

    always #5 clk = ~clk;

    logic_analyzer_trigger #(.NUM_PROBES(NP), .PROBE_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .probes(probes), .ops(ops), .args(args),
        .mode_or(mode_or), .match_count(match_count), .arm(arm),
        .trig(trig), .trig_state(trig_state), .run_length(run_length)
    );

    // Inputs present at each clock edge, indexed by edge number.
    bit          h_rst [MAXN];
    bit          h_arm [MAXN];
    bit          h_mode[MAXN];
    logic [15:0] h_pr  [MAXN];
    logic [15:0] h_args[MAXN];
    logic [15:0] h_cnt [MAXN];
    logic [7:0]  h_ops [MAXN];

    int n = 0;
    int checks = 0;
    int fails = 0;
    int exp_st = 0;
    int exp_run = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s (edge %0d): observed %h expected %h", tag, n, got, exp);
        end
    endtask

    function automatic logic [15:0] pval(int m);
        if (m < 0 || h_rst[m]) return 16'h0;
        return h_pr[m];
    endfunction

    function automatic bit op_hit(logic [3:0] op, logic [7:0] p, logic [7:0] q, logic [7:0] a, bit hv);
        case (op)
            4'd1:    return hv && (p > q);
            4'd2:    return hv && (p < q);
            4'd3:    return hv && (p != q);
            4'd4:    return p > a;
            4'd5:    return p < a;
            4'd6:    return p >= a;
            4'd7:    return p <= a;
            4'd8:    return p == a;
            4'd9:    return p != a;
            default: return 1'b0;
        endcase
    endfunction

    // Match for the sample captured at edge m, judged with the config present during the following cycle.
    function automatic bit sample_match(int m);
        logic [15:0] cur, prev, av;
        logic [7:0]  ov;
        bit          hv;
        int          nen, nhit;
        cur  = pval(m);
        prev = pval(m - 1);
        hv   = (m >= 1) && !h_rst[m] && !h_rst[m-1];
        av   = h_args[m+1];
        ov   = h_ops[m+1];
        nen  = 0;
        nhit = 0;
        for (int i = 0; i < NP; i++) begin
            if (ov[i*4 +: 4] >= 4'd1 && ov[i*4 +: 4] <= 4'd9) begin
                nen++;
                if (op_hit(ov[i*4 +: 4], cur[i*PW +: PW], prev[i*PW +: PW], av[i*PW +: PW], hv)) nhit++;
            end
        end
        if (nen == 0) return 1'b0;
        return h_mode[m+1] ? (nhit > 0) : (nhit == nen);
    endfunction

    task automatic step();
        bit mq, aprev;
        int thr;
        h_rst[n]  = rst;
        h_arm[n]  = arm;
        h_mode[n] = mode_or;
        h_pr[n]   = probes;
        h_args[n] = args;
        h_cnt[n]  = match_count;
        h_ops[n]  = ops;
        @(posedge clk);
        if (h_rst[n]) begin
            exp_st  = 0;
            exp_run = 0;
        end else begin
            mq    = (n >= 2) && !h_rst[n-1] && sample_match(n - 2);
            aprev = (n >= 1) && !h_rst[n-1] && h_arm[n-1];
            if (!h_arm[n]) begin
                exp_st  = 0;
                exp_run = 0;
            end else if (exp_st == 0) begin
                if (!aprev) begin
                    exp_st  = 1;
                    exp_run = 0;
                end
            end else if (exp_st == 1) begin
`ifdef LA_TRIGGER_COUNT_EN
                thr     = (h_cnt[n] == 16'd0) ? 1 : int'(h_cnt[n]);
                exp_run = mq ? ((exp_run < 65535) ? exp_run + 1 : exp_run) : 0;
                if (mq && exp_run >= thr) exp_st = 2;
`else
                thr = 0;
                if (mq) exp_st = 2;
`endif
            end
        end
        #1;
        check("trig", {15'd0, trig}, (exp_st == 2) ? 16'd1 : 16'd0);
        check("trig_state", {14'd0, trig_state}, 16'(exp_st));
        check("run_length", run_length, 16'(exp_run));
        n++;
    endtask

    function automatic logic [7:0] near(logic [7:0] a);
        case ($urandom_range(0, 3))
            0:       return a;
            1:       return a + 8'd1;
            2:       return a - 8'd1;
            default: return 8'($urandom);
        endcase
    endfunction

    logic [7:0]  cpat[8] = '{8'hAA, 8'hAA, 8'h00, 8'hAA, 8'hAA, 8'hAA, 8'h00, 8'h00};
    logic [15:0] crun[8] = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd0, 16'd1, 16'd2, 16'd3};

    initial begin
        // Reset held with arm high and matching probes.
        rst = 1'b1; arm = 1'b1; mode_or = 1'b0; match_count = 16'd1;
        ops = {4'd0, 4'd8}; args = 16'h005A; probes = 16'h005A;
        step(); step();
        check("rst_trig", {15'd0, trig}, 16'd0);
        check("rst_state", {14'd0, trig_state}, 16'd0);
        check("rst_run", run_length, 16'd0);

        // EQ single shot.
        rst = 1'b0; arm = 1'b0; probes = 16'h0000;
        step(); step();
        arm = 1'b1; step();
        probes = 16'h005A; step();
        probes = 16'h0000; step();
        check("eq_early", {15'd0, trig}, 16'd0);
        step();
        check("eq_fire", {15'd0, trig}, 16'd1);
        step(); step();
        check("eq_hold", {15'd0, trig}, 16'd1);
        arm = 1'b0; step();
        check("eq_drop", {15'd0, trig}, 16'd0);

        // RISING ignores the first sample after reset.
        rst = 1'b1; arm = 1'b1; ops = {4'd0, 4'd1}; probes = 16'h0000;
        step();
        rst = 1'b0; probes = 16'h0010; step();
        probes = 16'h0011; step();
        step();
        check("rise_early", {15'd0, trig}, 16'd0);
        step();
        check("rise_fire", {15'd0, trig}, 16'd1);

        // OR mode, then everything disabled.
        arm = 1'b0; ops = {4'd5, 4'd4}; args = 16'h0380; mode_or = 1'b1; probes = 16'h0120;
        step();
        arm = 1'b1; step(); step(); step();
        check("or_fire", {15'd0, trig}, 16'd1);
        arm = 1'b0; ops = 8'h00; step();
        arm = 1'b1;
        for (int i = 0; i < 8; i++) begin
            probes = 16'($urandom);
            step();
        end
        check("or_none", {15'd0, trig}, 16'd0);

        // Consecutive-match qualification with count 3.
        arm = 1'b0; ops = {4'd0, 4'd8}; args = 16'h00AA; mode_or = 1'b0; match_count = 16'd3;
        probes = 16'h0000; step();
        arm = 1'b1; step();
        for (int i = 0; i < 8; i++) begin
            probes = {8'h00, cpat[i]};
            step();
`ifdef LA_TRIGGER_COUNT_EN
            check("cnt_run", run_length, crun[i]);
            check("cnt_trig", {15'd0, trig}, (i >= 7) ? 16'd1 : 16'd0);
`else
            check("cnt_trig", {15'd0, trig}, (i >= 2) ? 16'd1 : 16'd0);
`endif
        end

        // Randomized segments: new config while disarmed, arm, then mixed traffic.
        for (int seg = 0; seg < 40; seg++) begin
            arm = 1'b0;
            ops = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
            args = 16'($urandom);
            mode_or = 1'($urandom_range(0, 1));
            match_count = 16'($urandom_range(0, 4));
            probes = 16'($urandom);
            rst = ($urandom_range(0, 7) == 0);
            step();
            rst = ($urandom_range(0, 5) == 0);
            arm = 1'b1;
            step();
            rst = 1'b0;
            for (int c = 0; c < 25; c++) begin
                probes = {near(args[15:8]), near(args[7:0])};
                rst = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 29) == 0) arm = ~arm;
                step();
                rst = 1'b0;
                arm = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
